// File: rtl/wb_regfile.sv
// Write-back stage and 32 x DATA_W architectural register file.
// Selects the write-back value, commits it on clk, and serves two bypassed combinational read ports.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_2_reg,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs_addr_i,
    input  logic [4:0]        rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_valid_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    logic [DATA_W-1:0] r_regs [32];
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_valid;

    assign w_wb_data  = mem_2_reg ? mem_data_i : alu_result_i;
    assign w_wb_valid = rst_n & reg_write & (rd_i != 5'd0);

    // NOTE: the storage array is reset explicitly because reset must clear every
    // register at once; entry 0 is never written, so it stays zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_wb_valid) begin
            r_regs[rd_i] <= w_wb_data;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Same-cycle bypass keeps ID from seeing a value that is about to be overwritten.
    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] data;
        data = '0;
        if (rst_n && (addr != 5'd0)) begin
            if (w_wb_valid && (rd_i == addr)) begin
                data = w_wb_data;
            end else begin
                data = r_regs[addr];
            end
        end
        return data;
    endfunction

    // NOTE: every combinational output gets its default first, so no latch is inferred.
    always_comb begin
        rs_data_o = '0;
        rt_data_o = '0;
        rs_data_o = read_port(rs_addr_i);
        rt_data_o = read_port(rt_addr_i);
    end

    assign wb_data_o  = w_wb_data;
    assign wb_valid_o = w_wb_valid;
    assign wr_count_o = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a 4-bit counter, so that saturation is reachable.
// Inputs change 1 ns after a rising edge; outputs are checked mid-cycle.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              mem_2_reg;
    logic              reg_write;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs_addr_i;
    logic [4:0]        rt_addr_i;
    logic [DATA_W-1:0] rs_data_o;
    logic [DATA_W-1:0] rt_data_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_valid_o;
    logic [CNT_W-1:0]  wr_count_o;

    int passed = 0;
    int total  = 0;

    wb_regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_2_reg    (mem_2_reg),
        .reg_write    (reg_write),
        .mem_data_i   (mem_data_i),
        .alu_result_i (alu_result_i),
        .rd_i         (rd_i),
        .rs_addr_i    (rs_addr_i),
        .rt_addr_i    (rt_addr_i),
        .rs_data_o    (rs_data_o),
        .rt_data_o    (rt_data_o),
        .wb_data_o    (wb_data_o),
        .wb_valid_o   (wb_valid_o),
        .wr_count_o   (wr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                         input logic [DATA_W-1:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [4:0] rd,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        reg_write    = we;
        mem_2_reg    = m2r;
        rd_i         = rd;
        alu_result_i = alu;
        mem_data_i   = mem;
    endtask

    initial begin
        rst_n     = 1'b0;
        rs_addr_i = 5'd3;
        rt_addr_i = 5'd3;
        drive(1'b1, 1'b1, 5'd3, 32'h0000_0AAA, 32'h0000_0BBB);
        #3;
        // Reset state: ports and valid gated off, mux still live.
        check("rst_rs", rs_data_o, 32'h0);
        check("rst_rt", rt_data_o, 32'h0);
        check("rst_valid", {31'b0, wb_valid_o}, 32'h0);
        check("rst_count", {28'b0, wr_count_o}, 32'h0);
        check("rst_wbdata", wb_data_o, 32'h0000_0BBB);

        @(negedge clk);
        rst_n = 1'b1;
        reg_write = 1'b0;
        tick();

        // ALU result select and commit to r5.
        drive(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        rs_addr_i = 5'd5;
        #1;
        check("alu_wbdata", wb_data_o, 32'h1234_5678);
        check("alu_valid", {31'b0, wb_valid_o}, 32'h1);
        check("alu_bypass", rs_data_o, 32'h1234_5678);
        tick();
        reg_write = 1'b0;
        #1;
        check("alu_commit", rs_data_o, 32'h1234_5678);
        check("alu_count", {28'b0, wr_count_o}, 32'h1);

        // Memory data select and commit to r6.
        drive(1'b1, 1'b1, 5'd6, 32'h1234_5678, 32'hDEAD_BEEF);
        rt_addr_i = 5'd6;
        #1;
        check("mem_wbdata", wb_data_o, 32'hDEAD_BEEF);
        tick();
        reg_write = 1'b0;
        #1;
        check("mem_commit", rt_data_o, 32'hDEAD_BEEF);
        check("mem_count", {28'b0, wr_count_o}, 32'h2);

        // Bypass: r7 holds 0x11, then 0x22 is written while both ports read r7.
        drive(1'b1, 1'b0, 5'd7, 32'h11, 32'h0);
        tick();
        drive(1'b1, 1'b0, 5'd7, 32'h22, 32'h0);
        rs_addr_i = 5'd7;
        rt_addr_i = 5'd7;
        #1;
        check("byp_rs_pre", rs_data_o, 32'h22);
        check("byp_rt_pre", rt_data_o, 32'h22);
        tick();
        reg_write = 1'b0;
        #1;
        check("byp_rs_post", rs_data_o, 32'h22);
        check("byp_rt_post", rt_data_o, 32'h22);
        check("byp_count", {28'b0, wr_count_o}, 32'h4);

        // Register zero: write discarded, not counted, reads zero.
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rs_addr_i = 5'd0;
        rt_addr_i = 5'd0;
        #1;
        check("r0_valid", {31'b0, wb_valid_o}, 32'h0);
        check("r0_rs_pre", rs_data_o, 32'h0);
        tick();
        check("r0_rs_post", rs_data_o, 32'h0);
        check("r0_rt_post", rt_data_o, 32'h0);
        check("r0_count", {28'b0, wr_count_o}, 32'h4);

        // Bubble: reg_write low, no bypass, no commit.
        drive(1'b0, 1'b0, 5'd9, 32'hAA, 32'hAA);
        rs_addr_i = 5'd9;
        #1;
        check("bub_valid", {31'b0, wb_valid_o}, 32'h0);
        check("bub_rs_pre", rs_data_o, 32'h0);
        tick();
        check("bub_rs_post", rs_data_o, 32'h0);
        check("bub_count", {28'b0, wr_count_o}, 32'h4);

        // Mid-cycle reset: takes effect without a clock, blocks commits while low.
        rs_addr_i = 5'd5;
        #1;
        check("pre_rst_r5", rs_data_o, 32'h1234_5678);
        drive(1'b1, 1'b0, 5'd10, 32'h55, 32'h0);
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            rs_addr_i = 5'(a);
            rt_addr_i = 5'(a);
            #0.1;
            check($sformatf("rst_rs_a%0d", a), rs_data_o, 32'h0);
            check($sformatf("rst_rt_a%0d", a), rt_data_o, 32'h0);
        end
        check("rst_mid_count", {28'b0, wr_count_o}, 32'h0);
        check("rst_mid_valid", {31'b0, wb_valid_o}, 32'h0);
        tick();
        @(negedge clk);
        reg_write = 1'b0;
        rst_n = 1'b1;
        #1;
        rs_addr_i = 5'd10;
        rt_addr_i = 5'd5;
        #1;
        check("rst_nocommit_r10", rs_data_o, 32'h0);
        check("rst_cleared_r5", rt_data_o, 32'h0);
        check("rst_post_count", {28'b0, wr_count_o}, 32'h0);
        rs_addr_i = 5'd6;
        rt_addr_i = 5'd7;
        #1;
        check("rst_cleared_r6", rs_data_o, 32'h0);
        check("rst_cleared_r7", rt_data_o, 32'h0);

        // Saturation: 17 writes into r1..r17, counter stops at 15.
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 5'(i + 1), 32'h100 + 32'(i), 32'h0);
            tick();
            check($sformatf("sat_count_%0d", i + 1), {28'b0, wr_count_o},
                  (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        reg_write = 1'b0;
        rs_addr_i = 5'd17;
        rt_addr_i = 5'd1;
        #1;
        check("sat_last_data", rs_data_o, 32'h110);
        check("sat_first_data", rt_data_o, 32'h100);
        tick();
        check("sat_hold", {28'b0, wr_count_o}, 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the 5-stage pipeline, the consumer of the MEM/WB pipeline register's outputs. It selects the write-back value (memory load data or ALU result), commits it to a 32 x 32-bit register file on the clock edge, and serves two combinational read ports to ID with same-cycle write-through bypass. It also exports the selected write-back value and its validity for EX-stage forwarding, plus a saturating committed-write counter for debug.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- CNT_W, 16, width of the committed-write counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_2_reg  in  1  from MEM/WB: 1 = write back memory data, 0 = ALU result
- reg_write  in  1  from MEM/WB: write-back enable
- mem_data_i  in  DATA_W  from MEM/WB: memory read data
- alu_result_i  in  DATA_W  from MEM/WB: ALU result / address
- rd_i  in  5  from MEM/WB: destination register number
- rs_addr_i  in  5  ID read port A address
- rt_addr_i  in  5  ID read port B address
- rs_data_o  out  DATA_W  read port A data
- rt_data_o  out  DATA_W  read port B data
- wb_data_o  out  DATA_W  selected write-back value (forwarding source)
- wb_valid_o  out  1  write-back this cycle targets a real register
- wr_count_o  out  CNT_W  committed writes since reset, saturating

## Operation
- Write-back select: wb_data_o = mem_2_reg ? mem_data_i : alu_result_i. Purely combinational; no reset gating.
- wb_valid_o = rst_n & reg_write & (rd_i != 0).
- Commit: on the rising clk edge with wb_valid_o = 1, regs[rd_i] <= wb_data_o. No other register changes.
- Register 0 is hardwired zero. Writes to rd_i = 0 are discarded and not counted, and reads of address 0 return 0.
- Read port A: 0 if rs_addr_i = 0 or rst_n = 0. Otherwise wb_data_o if wb_valid_o and rd_i = rs_addr_i (bypass). Otherwise regs[rs_addr_i]. Port B is identical using rt_addr_i.
- Both ports may read the same address, including the address being written. Both then return the bypassed value.
- Counter: increments by 1 on each committed write. It holds at 2^CNT_W - 1 and never wraps.

## Timing
- Reset (rst_n low, asynchronous): regs[1..31] clear to 0 immediately, wr_count_o = 0, wb_valid_o = 0, rs_data_o = rt_data_o = 0. wb_data_o continues to follow its mux.
- Reset asserted mid-operation takes effect without waiting for clk. No write commits on any edge while rst_n is low.
- After rst_n deasserts, the first commit occurs on the first rising edge with wb_valid_o = 1.
- Read latency is 0 cycles (combinational from addresses and write-back inputs).
- A write is visible on the read ports in the same cycle it is presented (bypass) and from storage after the edge. ID therefore never sees a stale value for an instruction three ahead.
- Write latency: regs and wr_count_o update exactly 1 edge after wb_valid_o is sampled high.
- Handshake: none. MEM/WB presents a new bundle every cycle, and a bundle with reg_write = 0 is a bubble.
- Simultaneous saturation and write: the data commits and the counter stays at maximum.

## Test plan
- Reset check: drive regs via writes, then pulse rst_n low between edges. Reads of all 32 addresses -> 0 immediately; wr_count_o -> 0; no commit on the following edge while rst_n is still low.
- Select and commit: reg_write=1, mem_2_reg=0, alu_result_i=0x1234_5678, mem_data_i=0xDEAD_BEEF, rd_i=5. After the edge, rs_addr_i=5 -> 0x1234_5678 and wr_count_o=1. Repeat with mem_2_reg=1 and rd_i=6 -> regs[6]=0xDEAD_BEEF.
- Bypass: regs[7]=0x11. In the same cycle, write 0x22 to rd_i=7 with rs_addr_i=rt_addr_i=7 -> both ports read 0x22 before the edge and after it.
- Register zero: reg_write=1, rd_i=0, alu_result_i=0xFFFF_FFFF -> wb_valid_o=0, reads of address 0 return 0, wr_count_o unchanged.
- Bubble: reg_write=0, rd_i=9, data=0xAA -> regs[9] unchanged, no bypass on port reading 9, counter unchanged.
- Saturation with CNT_W=4: 17 consecutive valid writes -> wr_count_o stops at 15, and the 17th write's data is still committed.
